ram_req_ctrl: RTL and testbench
===============================

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 ADDR_W, 5, RAM word address width (32 words).
REQ-002 DATA_W, 32, data word width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  requester presents a request.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  request word address.
REQ-009 req_wdata  input  DATA_W  write data.
REQ-010 rsp_valid  output  1  read data available.
REQ-011 rsp_ready  input  1  requester takes read data.
REQ-012 rsp_rdata  output  DATA_W  read data.
REQ-013 ram_ena  output  1  to RAM ena, registered.
REQ-014 ram_wena  output  1  to RAM wena, registered.
REQ-015 ram_addr  output  ADDR_W  to RAM addr, registered.
REQ-016 ram_data_in  output  DATA_W  to RAM data_in, registered.
REQ-017 ram_data_out  input  DATA_W  from RAM data_out; valid in the same cycle as ram_ena=1, ram_wena=0.
REQ-018 init_done  output  1  RAM contents initialised, requests allowed.

Function
REQ-019 FSM states INIT, IDLE, ACCESS, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE with init_done=1; transfer = req_valid && req_ready at rising edge; req_* otherwise ignored, no queueing.
REQ-021 On transfer, next cycle is ACCESS: ram_ena=1, ram_wena=req_we, ram_addr/ram_data_in = captured req_addr/req_wdata, for exactly one cycle.
REQ-022 Write: ACCESS -> IDLE, no response; max throughput one write per 2 cycles.
REQ-023 Read: ram_data_out captured into rsp_rdata at end of ACCESS; ACCESS -> RESP; rsp_valid=1 throughout RESP.
REQ-024 RESP: rsp_valid/rsp_rdata held stable until rsp_valid && rsp_ready, then -> IDLE; with rsp_ready=1, accept at edge E0 gives rsp_valid high between E1 and E2.
REQ-025 Outside ACCESS/INIT: ram_ena=0, ram_wena=0; ram_addr/ram_data_in hold last value.
REQ-026 Full address range 0..2^ADDR_W-1 legal; no bounds check.
REQ-027 INIT (macro on): ram_ena=ram_wena=1, ram_data_in=0, ram_addr steps 0..2^ADDR_W-1, one per cycle; after last address -> IDLE, init_done=1 until next reset; counter never wraps.

Reset
REQ-028 At rst edge: rsp_valid=0, rsp_rdata=0, ram_ena=0, ram_wena=0, ram_addr=0, ram_data_in=0; state -> INIT with init_done=0 (macro on) or IDLE with init_done=1 (macro off).
REQ-029 Reset during ACCESS/RESP aborts; pending response dropped; a write whose ACCESS cycle ends on the reset edge is committed (RAM itself is not reset).
REQ-030 Reset during INIT restarts the sweep at address 0.

Configuration
REQ-031 Macro RAM_REQ_CTRL_INIT_EN: defined -> INIT zero-fill sweep after every reset; undefined -> INIT state and counter absent, IDLE directly after reset, RAM contents undefined until written.

Structure
REQ-032 Package ram_ctrl_pkg holds state enum, ADDR_W/DATA_W defaults; no sub-module, existing RAM instantiated alongside by integrator.

Verification
REQ-033 Macro on, reset -> 32 cycles of ram writes, addr 0..31, data 00000000; init_done=1 after; read addr 5 -> 00000000.
REQ-034 Writes A5A5A5A5@1, 5A5A5A5A@2, 12345678@3 with req_valid held -> req_ready every other cycle, three single-cycle RAM writes; reads @1,@2,@3 return the same values in order.
REQ-035 Read @3 with rsp_ready=0 for 4 cycles -> rsp_valid=1, rsp_rdata=12345678 stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-036 Write 77777777@0 then read @0 -> 77777777; write/read @31 boundary -> correct data.
REQ-037 rst during RESP -> rsp_valid=0 next cycle, sweep restarts at 0; rst at INIT addr 10 -> sweep restarts at 0.
REQ-038 Macro off: req_ready=1 first cycle after reset; no ram_ena activity before the first request.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the RAM request controller.
//   ADDR_W_DEF  : default RAM word address width (32 words)
//   DATA_W_DEF  : default RAM data word width
//   ctrlState_t : controller state encoding (INIT, IDLE, ACCESS, RESP)
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } ctrlState_t;

endpackage

// File: rtl/ram_req_ctrl.sv
// ---------------------------------------------------------------------------
// ram_req_ctrl
// Turns a valid/ready request stream into single-cycle accesses of an
// external single-port RAM that returns read data in the same cycle as the
// access. Reads are returned on a valid/ready response channel; writes give
// no response. Only one request is in flight at a time.
//
// Optional feature (macro RAM_REQ_CTRL_INIT_EN):
//   defined   -> after every reset the RAM is zero-filled, one word per cycle,
//                before requests are accepted (init_done rises afterwards)
//   undefined -> requests are accepted straight after reset
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_we, req_addr,
//   req_wdata           : request command, word address, write data
//   rsp_valid/rsp_ready : read response handshake
//   rsp_rdata           : read data, held stable while rsp_valid is high
//   ram_ena, ram_wena,
//   ram_addr,
//   ram_data_in         : registered RAM controls
//   ram_data_out        : RAM read data, valid while ram_ena=1 and ram_wena=0
//   init_done           : RAM initialised, requests allowed
// ---------------------------------------------------------------------------
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              init_done
);

    ctrlState_t        state_q;
    logic              ramEna_q;
    logic              ramWena_q;
    logic [ADDR_W-1:0] ramAddr_q;
    logic [DATA_W-1:0] ramDataIn_q;
    logic              rspValid_q;
    logic [DATA_W-1:0] rspRdata_q;
    logic              initDone_q;
    logic              reqXfer;

`ifdef RAM_REQ_CTRL_INIT_EN
    // One bit wider than the address so the top bit marks "sweep finished"
    // and the counter stops there instead of wrapping.
    logic [ADDR_W:0]   initCnt_q;
`endif

    // Requests are only taken when nothing is in flight and the RAM is ready.
    assign req_ready = (state_q == IDLE) && initDone_q;
    assign reqXfer   = req_valid && req_ready;

    assign ram_ena     = ramEna_q;
    assign ram_wena    = ramWena_q;
    assign ram_addr    = ramAddr_q;
    assign ram_data_in = ramDataIn_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_rdata   = rspRdata_q;
    assign init_done   = initDone_q;

    // Controller FSM with all RAM and response outputs registered.
    // ram_ena/ram_wena default low every cycle so they pulse for exactly
    // one cycle per access; address and write data keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramEna_q    <= 1'b0;
            ramWena_q   <= 1'b0;
            ramAddr_q   <= '0;
            ramDataIn_q <= '0;
            rspValid_q  <= 1'b0;
            rspRdata_q  <= '0;
`ifdef RAM_REQ_CTRL_INIT_EN
            state_q     <= INIT;
            initDone_q  <= 1'b0;
            initCnt_q   <= '0;
`else
            state_q     <= IDLE;
            initDone_q  <= 1'b1;
`endif
        end else begin
            ramEna_q  <= 1'b0;
            ramWena_q <= 1'b0;
            case (state_q)
`ifdef RAM_REQ_CTRL_INIT_EN
                INIT: begin
                    // The cycle after the last zero write is issued, that
                    // write completes and the controller opens for requests.
                    if (initCnt_q[ADDR_W]) begin
                        state_q    <= IDLE;
                        initDone_q <= 1'b1;
                    end else begin
                        ramEna_q    <= 1'b1;
                        ramWena_q   <= 1'b1;
                        ramAddr_q   <= initCnt_q[ADDR_W-1:0];
                        ramDataIn_q <= '0;
                        initCnt_q   <= initCnt_q + (ADDR_W+1)'(1);
                    end
                end
`endif
                IDLE: begin
                    if (reqXfer) begin
                        ramEna_q    <= 1'b1;
                        ramWena_q   <= req_we;
                        ramAddr_q   <= req_addr;
                        ramDataIn_q <= req_wdata;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // ramWena_q still holds the command of this access.
                    if (ramWena_q) begin
                        state_q <= IDLE;
                    end else begin
                        rspRdata_q <= ram_data_out;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_req_ctrl
// Self-checking bench for ram_req_ctrl with a behavioural RAM attached.
// A transaction-level model (shadow memory, pending access and response
// queues, init sweep step count) is compared against the DUT every cycle;
// directed sequences add hand-computed expectations.
// Works with and without RAM_REQ_CTRL_INIT_EN.
// ---------------------------------------------------------------------------
module tb_ram_req_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic              init_done;

    int checkCount = 0;
    int failCount  = 0;

    ram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .ram_ena      (ram_ena),
        .ram_wena     (ram_wena),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the rising edge.
    logic [DATA_W-1:0] ramMem [WORDS];
    assign ram_data_out = ramMem[ram_addr];
    always @(posedge clk) begin
        if (ram_ena && ram_wena) ramMem[ram_addr] <= ram_data_in;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checkCount++;
        failCount++;
        $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Model: what the outputs must be, derived from transfers and rules.
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } access_t;

    access_t           accQ[$];
    logic [DATA_W-1:0] rspQ[$];
    logic [DATA_W-1:0] shadow [WORDS];
    access_t           curAcc;
    bit                modelOn = 1'b0;
    bit                expInitDone;
    bit                expReady;
    int                initStep;
    logic [ADDR_W-1:0] lastAddr;
    logic [DATA_W-1:0] lastData;

    // Per-cycle comparison at the falling edge, then advance the model by
    // the inputs the DUT will sample at the next rising edge.
    always @(negedge clk) begin
        if (modelOn) begin
            expReady = expInitDone && (accQ.size() == 0) && (rspQ.size() == 0);
            checkOutput("init_done", init_done, expInitDone);
            checkOutput("req_ready", req_ready, expReady);
            checkOutput("rsp_valid", rsp_valid, rspQ.size() != 0);
            if (rspQ.size() != 0) checkOutput("rsp_rdata", rsp_rdata, rspQ[0]);
            if (!expInitDone && initStep >= 1) begin
                checkOutput("init ram_ena", ram_ena, 1);
                checkOutput("init ram_wena", ram_wena, 1);
                checkOutput("init ram_addr", ram_addr, initStep - 1);
                checkOutput("init ram_data_in", ram_data_in, 0);
                lastAddr = ADDR_W'(initStep - 1);
                lastData = '0;
            end else if (accQ.size() != 0) begin
                checkOutput("acc ram_ena", ram_ena, 1);
                checkOutput("acc ram_wena", ram_wena, accQ[0].we);
                checkOutput("acc ram_addr", ram_addr, accQ[0].addr);
                checkOutput("acc ram_data_in", ram_data_in, accQ[0].data);
                lastAddr = accQ[0].addr;
                lastData = accQ[0].data;
            end else begin
                checkOutput("idle ram_ena", ram_ena, 0);
                checkOutput("idle ram_wena", ram_wena, 0);
                checkOutput("hold ram_addr", ram_addr, lastAddr);
                checkOutput("hold ram_data_in", ram_data_in, lastData);
            end
        end
        if (rst) begin
            // A write whose access cycle ends on the reset edge still lands.
            if (modelOn && !expInitDone && initStep >= 1) shadow[initStep - 1] = '0;
            if (modelOn && accQ.size() != 0 && accQ[0].we) shadow[accQ[0].addr] = accQ[0].data;
            accQ.delete();
            rspQ.delete();
            lastAddr = '0;
            lastData = '0;
            initStep = 0;
`ifdef RAM_REQ_CTRL_INIT_EN
            expInitDone = 1'b0;
`else
            expInitDone = 1'b1;
`endif
            modelOn = 1'b1;
        end else if (modelOn) begin
            if (!expInitDone) begin
                if (initStep >= 1) shadow[initStep - 1] = '0;
                initStep++;
                if (initStep == WORDS + 1) expInitDone = 1'b1;
            end else begin
                if (rspQ.size() != 0 && rsp_ready) void'(rspQ.pop_front());
                if (accQ.size() != 0) begin
                    curAcc = accQ.pop_front();
                    if (curAcc.we) shadow[curAcc.addr] = curAcc.data;
                    else rspQ.push_back(shadow[curAcc.addr]);
                end
                if (req_valid && expReady) accQ.push_back('{req_we, req_addr, req_wdata});
            end
        end
    end

    // Present a request and hold it until accepted; returns the number of
    // falling edges observed up to and including the one showing ready.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input bit keepValid,
                                 output int waited);
        bit got = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        waited    = 0;
        while (!got && waited < 100) begin
            @(negedge clk);
            waited++;
            got = req_ready;
        end
        if (!got) reportTimeout("request accept");
        @(posedge clk);
        #1;
        if (!keepValid) req_valid = 1'b0;
    endtask

    task automatic waitRsp(output int lat);
        bit got = 1'b0;
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = rsp_valid;
        end
        if (!got) reportTimeout("response");
    endtask

    task automatic waitInitDone();
        bit got = 1'b0;
        int n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = init_done;
        end
        if (!got) reportTimeout("init_done");
        @(posedge clk);
        #1;
    endtask

    task automatic readExpect(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp,
                              input string name);
        int w;
        int lat;
        applyStimulus(1'b0, addr, '0, 1'b0, w);
        waitRsp(lat);
        checkOutput({name, " latency"}, lat, 2);
        checkOutput(name, rsp_rdata, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int w;
        int lat;
        int sweepWrites;
        bit found;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_rdata", rsp_rdata, 0);
        checkOutput("reset ram_addr", ram_addr, 0);
`ifdef RAM_REQ_CTRL_INIT_EN
        checkOutput("reset init_done", init_done, 0);
        sweepWrites = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (ram_ena && ram_wena) sweepWrites++;
            found = init_done;
        end
        checkOutput("sweep write count", sweepWrites, 32);
        @(posedge clk);
        #1;
        readExpect(5'd5, 32'h0000_0000, "read after init @5");
`else
        checkOutput("ready after reset", req_ready, 1);
        checkOutput("no ram_ena after reset", ram_ena, 0);
        @(posedge clk);
        #1;
`endif

        // Back-to-back writes with req_valid held high.
        applyStimulus(1'b1, 5'd1, 32'hA5A5_A5A5, 1'b1, w);
        applyStimulus(1'b1, 5'd2, 32'h5A5A_5A5A, 1'b1, w);
        checkOutput("write spacing 2", w, 2);
        applyStimulus(1'b1, 5'd3, 32'h1234_5678, 1'b0, w);
        checkOutput("write spacing 3", w, 2);
        readExpect(5'd1, 32'hA5A5_A5A5, "read @1");
        readExpect(5'd2, 32'h5A5A_5A5A, "read @2");
        readExpect(5'd3, 32'h1234_5678, "read @3");

        // Response back-pressure: data held, no new requests.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 5'd3, '0, 1'b0, w);
        waitRsp(lat);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall rsp_valid", rsp_valid, 1);
            checkOutput("stall rsp_rdata", rsp_rdata, 32'h1234_5678);
            checkOutput("stall req_ready", req_ready, 0);
            if (i < 3) @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("release rsp_valid", rsp_valid, 1);
        @(negedge clk);
        checkOutput("after release rsp_valid", rsp_valid, 0);
        checkOutput("after release req_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // Address boundaries.
        applyStimulus(1'b1, 5'd0, 32'h7777_7777, 1'b0, w);
        readExpect(5'd0, 32'h7777_7777, "read @0");
        applyStimulus(1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, w);
        readExpect(5'd31, 32'hDEAD_BEEF, "read @31");

        // Reset while a response is pending drops it.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 5'd2, '0, 1'b0, w);
        waitRsp(lat);
        @(posedge clk);
        #1;
        pulseReset();
        @(negedge clk);
        checkOutput("reset in RESP rsp_valid", rsp_valid, 0);
        checkOutput("reset in RESP rsp_rdata", rsp_rdata, 0);
        checkOutput("reset in RESP ram_addr", ram_addr, 0);
        rsp_ready = 1'b1;
`ifdef RAM_REQ_CTRL_INIT_EN
        @(negedge clk);
        checkOutput("sweep restart ena", ram_ena, 1);
        checkOutput("sweep restart addr", ram_addr, 0);
`endif
        waitInitDone();

        // A write whose access cycle ends on the reset edge is committed.
        applyStimulus(1'b1, 5'd4, 32'h1122_3344, 1'b0, w);
        pulseReset();
        waitInitDone();
`ifdef RAM_REQ_CTRL_INIT_EN
        readExpect(5'd4, 32'h0000_0000, "read @4 after reset");
`else
        readExpect(5'd4, 32'h1122_3344, "read @4 after reset");
`endif

`ifdef RAM_REQ_CTRL_INIT_EN
        // Reset part-way through the sweep restarts it from address 0.
        pulseReset();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = ram_ena && (ram_addr == 5'd9);
        end
        if (!found) reportTimeout("sweep addr 9");
        @(posedge clk);
        #1;
        pulseReset();
        @(negedge clk);
        checkOutput("mid-sweep reset ena", ram_ena, 0);
        checkOutput("mid-sweep reset addr", ram_addr, 0);
        @(negedge clk);
        checkOutput("mid-sweep restart ena", ram_ena, 1);
        checkOutput("mid-sweep restart addr", ram_addr, 0);
        waitInitDone();
        readExpect(5'd10, 32'h0000_0000, "read @10 after sweep");
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
